// File: rtl/cargador_pkg.sv
// Shared definitions for the program loader: FSM state encodings,
// default geometry and the byte-lane selection helper.
package cargador_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } estado_t;

  // Lane (0 = bits [7:0], 3 = bits [31:24]) that the byte at position
  // cnt within a word lands in.
  function automatic logic [1:0] lane_idx(input logic [1:0] cnt,
                                          input logic       big_endian);
    return big_endian ? (2'd3 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/cargador_instrucciones_empaquetador.sv
// Byte-to-word packer. Collects up to four bytes into a lane register and
// emits a registered word with a single-cycle word_ready pulse when the
// fourth byte arrives or when the stream ends early (missing lanes are 0).
module empaquetador_palabra
  import cargador_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        last,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_cnt,
  output logic        word_ready,
  output logic [31:0] word_data
);

  logic [3:0][7:0] lanes_q, lanes_d, merged;
  logic [1:0]      cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [31:0]     data_q, data_d;

  // Insert the incoming byte into its lane; close the word on the fourth
  // byte or on the last byte of the stream. Lanes restart from zero for
  // every word, which is what gives the zero-fill on a short final word.
  always_comb begin
    merged  = lanes_q;
    merged[lane_idx(cnt_q, BIG_ENDIAN)] = byte_in;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    data_d  = data_q;
    if (clr) begin
      lanes_d = '0;
      cnt_d   = 2'd0;
    end else if (push) begin
      if (cnt_q == 2'd3 || last) begin
        ready_d = 1'b1;
        data_d  = merged;
        lanes_d = '0;
        cnt_d   = 2'd0;
      end else begin
        lanes_d = merged;
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  // Packer state; the async reset also kills a word pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q <= '0;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign byte_cnt   = cnt_q;
  assign word_ready = ready_q;
  assign word_data  = data_q;

endmodule

// File: rtl/cargador_instrucciones.sv
// Program loader: receives a byte stream, packs it into 32-bit words and
// writes them to consecutive instruction-memory addresses while holding
// the core in reset. The core is released only after a clean load.
// DEPTH is expected to equal 2**ADDR_W.
module cargador_instrucciones
  import cargador_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DEPTH         = DEF_DEPTH,
  parameter bit BIG_ENDIAN    = 1'b1,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  estado_t           state_q, state_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              xfer, full, push, clr, word_end;
  logic [1:0]        byte_cnt;

  assign byte_ready = (state_q == ST_LOAD);
  assign xfer       = byte_valid && byte_ready;
  // Memory already full: the next byte is an overflow and must not reach
  // the packer, so no 65th word and no address wrap.
  assign full       = (word_count_q == DEPTH_CNT);
  assign push       = xfer && !full;
  assign word_end   = push && (byte_cnt == 2'd3 || byte_last);

  empaquetador_palabra #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_empaquetador (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .push       (push),
    .last       (byte_last),
    .byte_in    (byte_in),
    .byte_cnt   (byte_cnt),
    .word_ready (wr_en),
    .word_data  (wr_data)
  );

  // Next-state, address/count bookkeeping and core-hold control.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    wr_addr_d    = wr_addr_q;
    cpu_hold_d   = cpu_hold_q;
    clr          = 1'b0;
    // The address is latched alongside the packer's registered word so
    // wr_addr and wr_data appear together on the write cycle.
    if (word_end) begin
      wr_addr_d    = word_count_q[ADDR_W-1:0];
      word_count_d = word_count_q + CNT_ONE;
    end
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LOAD;
          word_count_d = '0;
          cpu_hold_d   = 1'b1;
          clr          = 1'b1;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (full) begin
            state_d = ST_ERR;
          end else if (byte_last) begin
            if (byte_cnt == 2'd3) begin
              state_d    = ST_DONE;
              cpu_hold_d = 1'b0;
            end else begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d    = ST_DONE;
        cpu_hold_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      wr_addr_q    <= '0;
      cpu_hold_q   <= HOLD_AT_RESET;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      wr_addr_q    <= wr_addr_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign cpu_hold   = cpu_hold_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Directed bench for the program loader. A big-endian and a little-endian
// instance share the same stimulus; writes are logged on the falling edge.
module tb_cargador_instrucciones;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;

  logic        byte_ready, wr_en, cpu_hold, busy, done, error;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  word_count;

  logic        le_byte_ready, le_wr_en, le_cpu_hold, le_busy, le_done, le_error;
  logic [5:0]  le_wr_addr;
  logic [31:0] le_wr_data;
  logic [6:0]  le_word_count;

  int errors = 0;
  int checks = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  logic [31:0] le_wd[$];

  always #5 clk = ~clk;

  cargador_instrucciones #(.ADDR_W(6), .DEPTH(64), .BIG_ENDIAN(1'b1), .HOLD_AT_RESET(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  cargador_instrucciones #(.ADDR_W(6), .DEPTH(64), .BIG_ENDIAN(1'b0), .HOLD_AT_RESET(1'b1)) u_dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(le_byte_ready),
    .wr_en(le_wr_en), .wr_addr(le_wr_addr), .wr_data(le_wr_data), .cpu_hold(le_cpu_hold),
    .busy(le_busy), .done(le_done), .error(le_error), .word_count(le_word_count)
  );

  // Write log, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (le_wr_en) le_wd.push_back(le_wr_data);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); le_wd.delete();
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, busy, done, error, byte_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {wr_en, busy, done, error, byte_ready});
    end
    checks++;
    if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    checks++;
    if (word_count !== 7'd0) begin errors++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] prog [8];
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    clear_log();
    start_pulse();
    checks++;
    if ({busy, cpu_hold, byte_ready} !== 3'b111) begin
      errors++; $display("FAIL basic_loading: got %b expected 111", {busy, cpu_hold, byte_ready});
    end
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    @(negedge clk);
    checks++;
    if (wa.size() != 2) begin
      errors++; $display("FAIL basic_nwrites: got %0d expected 2", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 6'd0 || wd[0] !== 32'h20080005) begin
        errors++; $display("FAIL basic_word0: got addr %0d data %h expected addr 0 data 20080005", wa[0], wd[0]);
      end
      checks++;
      if (wa[1] !== 6'd1 || wd[1] !== 32'h20090007) begin
        errors++; $display("FAIL basic_word1: got addr %0d data %h expected addr 1 data 20090007", wa[1], wd[1]);
      end
    end
    checks++;
    if ({done, cpu_hold, busy, error} !== 4'b1000) begin
      errors++; $display("FAIL basic_status: got %b expected 1000", {done, cpu_hold, busy, error});
    end
    checks++;
    if (word_count !== 7'd2) begin errors++; $display("FAIL basic_word_count: got %0d expected 2", word_count); end
  endtask

  // Runs from DONE: the stream must be refused
  task automatic test_backpressure();
    int bad = 0;
    clear_log();
    byte_in = 8'h55; byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (byte_ready !== 1'b0) bad++;
    end
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_ready: got %0d ready cycles expected 0", bad); end
    checks++;
    if (wa.size() != 0) begin errors++; $display("FAIL bp_writes: got %0d expected 0", wa.size()); end
    checks++;
    if (done !== 1'b1 || word_count !== 7'd2) begin
      errors++; $display("FAIL bp_state: got done %b count %0d expected done 1 count 2", done, word_count);
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    start_pulse();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    start = 1'b1;
    send_byte(8'h05, 1'b0);
    start = 1'b0;
    for (int i = 6; i <= 8; i++) send_byte(8'(i), i == 8);
    @(negedge clk);
    checks++;
    if (wa.size() != 2) begin
      errors++; $display("FAIL b2b_nwrites: got %0d expected 2", wa.size());
    end else begin
      checks++;
      if (wa[1] !== 6'd1 || wd[0] !== 32'h01020304 || wd[1] !== 32'h05060708) begin
        errors++; $display("FAIL b2b_words: got addr1 %0d data %h %h expected 1 01020304 05060708", wa[1], wd[0], wd[1]);
      end
    end
    checks++;
    if (word_count !== 7'd2 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_status: got count %0d done %b expected 2 1", word_count, done);
    end
  endtask

  task automatic test_partial();
    clear_log();
    start_pulse();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b1) begin
      errors++; $display("FAIL partial_flush: got busy %b wr_en %b expected 1 1", busy, wr_en);
    end
    @(negedge clk);
    checks++;
    if (wa.size() != 1) begin
      errors++; $display("FAIL partial_nwrites: got %0d expected 1", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 6'd0 || wd[0] !== 32'hAABB0000) begin
        errors++; $display("FAIL partial_word: got addr %0d data %h expected addr 0 data aabb0000", wa[0], wd[0]);
      end
    end
    checks++;
    if (done !== 1'b1 || word_count !== 7'd1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL partial_status: got done %b count %0d hold %b expected 1 1 0", done, word_count, cpu_hold);
    end
  endtask

  task automatic test_endianness();
    clear_log();
    start_pulse();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    @(negedge clk);
    checks++;
    if (le_wd.size() != 1 || le_wd[0] !== 32'h44332211) begin
      errors++; $display("FAIL endian_little: got %0d writes first %h expected 1 write 44332211", le_wd.size(), le_wd[0]);
    end
    checks++;
    if (wd.size() != 1 || wd[0] !== 32'h11223344) begin
      errors++; $display("FAIL endian_big: got %0d writes first %h expected 1 write 11223344", wd.size(), wd[0]);
    end
  endtask

  // 256 bytes; with_last ends on the final byte, otherwise one extra byte
  task automatic run_full(input logic with_last);
    clear_log();
    start_pulse();
    for (int i = 0; i < 256; i++) send_byte(8'(i), with_last && (i == 255));
    if (!with_last) send_byte(8'hEE, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_full_exact();
    run_full(1'b1);
    checks++;
    if (wa.size() != 64) begin errors++; $display("FAIL exact_nwrites: got %0d expected 64", wa.size()); end
    checks++;
    if ({done, error, cpu_hold} !== 3'b100 || word_count !== 7'd64) begin
      errors++; $display("FAIL exact_status: got done/err/hold %b count %0d expected 100 64", {done, error, cpu_hold}, word_count);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    logic [31:0] exp;
    run_full(1'b0);
    checks++;
    if (wa.size() != 64) begin
      errors++; $display("FAIL ovf_nwrites: got %0d expected 64", wa.size());
    end else begin
      for (int k = 0; k < 64; k++) begin
        exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
        if (wa[k] !== 6'(k) || wd[k] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ovf_words: got %0d bad words expected 0", bad); end
    end
    checks++;
    if ({error, cpu_hold, byte_ready, busy, done} !== 5'b11000) begin
      errors++; $display("FAIL ovf_status: got %b expected 11000", {error, cpu_hold, byte_ready, busy, done});
    end
    checks++;
    if (word_count !== 7'd64) begin errors++; $display("FAIL ovf_word_count: got %0d expected 64", word_count); end
  endtask

  task automatic test_abort();
    // Reset while a word write is in flight cancels the strobe at once
    clear_log();
    start_pulse();
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_inflight: got wr_en %b expected 0", wr_en); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset after 5 bytes of a load
    start_pulse();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    rst_n = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0", wa.size()); end
    checks++;
    if ({wr_en, busy, done, error, byte_ready, cpu_hold} !== 6'b000001 || word_count !== 7'd0) begin
      errors++; $display("FAIL abort_outputs: got %b count %0d expected 000001 0",
                         {wr_en, busy, done, error, byte_ready, cpu_hold}, word_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_pulse();
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h0D, 1'b1);
    @(negedge clk);
    checks++;
    if (wa.size() != 1 || wa[0] !== 6'd0 || wd[0] !== 32'h0A0B0C0D) begin
      errors++; $display("FAIL abort_reload: got %0d writes addr %0d data %h expected 1 write addr 0 data 0a0b0c0d",
                         wa.size(), wa[0], wd[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_partial();
    test_endianness();
    test_full_exact();
    test_overflow();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
